// File: rtl/system_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : system_btn_debounce
// Purpose  : Two-flop synchroniser and per-channel debouncer for active-low
//            push buttons. Drives clean levels to the button PIO in_port and
//            emits one-cycle press/release strobes. Defining the macro
//            BTN_DEBOUNCE_REPEAT_EN adds per-channel auto-repeat: the level is
//            lifted high briefly so the PIO sees a new falling edge.
// Revision : 1.0  initial release
// ============================================================================
module system_btn_debounce #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000,
   parameter int GAP_CYCLES      = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] btn_n_in,
   output logic [WIDTH-1:0] btn_out,
   output logic [WIDTH-1:0] press,
   output logic [WIDTH-1:0] released
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_DEBOUNCE_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   // The same timer also counts out the gap, so it must cover GAP_CYCLES too.
   localparam int TMR_MAX = (RPT_MAX > GAP_CYCLES) ? RPT_MAX : GAP_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);
   localparam logic [TMR_W-1:0] GAP_LAST    = TMR_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2,
      ST_RPT  = 2'd3
   } rpt_state_t;
`else
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || GAP_CYCLES < 3) begin : g_rpt_params_unused
   end
`endif

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= btn_n_in;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             db_q;
      logic             db_nxt;
      logic             commit;
      logic             out_q;
      logic             out_nxt;
      logic             press_q;
      logic             press_nxt;
      logic             rel_q;
      logic             rel_nxt;
`ifdef BTN_DEBOUNCE_REPEAT_EN
      rpt_state_t       state;
      rpt_state_t       state_nxt;
      logic [TMR_W-1:0] tmr;
      logic [TMR_W-1:0] tmr_nxt;
`endif

      always_comb begin
         cnt_nxt = '0;
         db_nxt  = db_q;
         commit  = 1'b0;
         // The comparison is always against the debounced level, never the
         // gapped output, so a repeat gap cannot restart the debounce count.
         if (sync2[i] != db_q) begin
            if (cnt == CNT_LAST) begin
               commit = 1'b1;
               db_nxt = sync2[i];
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         press_nxt = commit & ~db_nxt;
         rel_nxt   = commit & db_nxt;
         out_nxt   = db_nxt;
`ifdef BTN_DEBOUNCE_REPEAT_EN
         state_nxt = state;
         tmr_nxt   = tmr + 1'b1;
         if (rel_nxt) begin
            state_nxt = ST_IDLE;
            tmr_nxt   = '0;
         end else if (press_nxt) begin
            state_nxt = ST_HOLD;
            tmr_nxt   = '0;
         end else begin
            case (state)
               ST_IDLE: tmr_nxt = '0;
               ST_HOLD: begin
                  if (tmr == DELAY_LAST) begin
                     state_nxt = ST_GAP;
                     tmr_nxt   = '0;
                  end
               end
               ST_GAP: begin
                  if (tmr == GAP_LAST) begin
                     state_nxt = ST_RPT;
                     tmr_nxt   = '0;
                     press_nxt = 1'b1;
                  end
               end
               ST_RPT: begin
                  if (tmr == PERIOD_LAST) begin
                     state_nxt = ST_GAP;
                     tmr_nxt   = '0;
                  end
               end
               default: begin
                  state_nxt = ST_IDLE;
                  tmr_nxt   = '0;
               end
            endcase
         end
         out_nxt = db_nxt | (state_nxt == ST_GAP);
`endif
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt     <= '0;
            db_q    <= 1'b1;
            out_q   <= 1'b1;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
            state   <= ST_IDLE;
            tmr     <= '0;
`endif
         end else begin
            cnt     <= cnt_nxt;
            db_q    <= db_nxt;
            out_q   <= out_nxt;
            press_q <= press_nxt;
            rel_q   <= rel_nxt;
`ifdef BTN_DEBOUNCE_REPEAT_EN
            state   <= state_nxt;
            tmr     <= tmr_nxt;
`endif
         end
      end

      assign btn_out[i]  = out_q;
      assign press[i]    = press_q;
      assign released[i] = rel_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_system_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_system_btn_debounce
// Purpose  : Directed and randomized bench for system_btn_debounce, checked
//            against a sample-window reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_system_btn_debounce;

   localparam int W  = 4;
   localparam int D  = 8;
   localparam int RD = 40;
   localparam int RP = 20;
   localparam int G  = 4;

   logic         clk     = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] btn_n_in = '0;
   logic [W-1:0] btn_out;
   logic [W-1:0] press;
   logic [W-1:0] released;

   int checks = 0;
   int errors = 0;
   int press_seen [W];
   int rel_seen   [W];
   int rem        [W];

   // Reference model: q[k] holds the input sampled k+1 edges ago.
   logic [W-1:0] q [0:D];
   logic [W-1:0] mdb;
   logic [W-1:0] mgap;
   logic [W-1:0] mpress;
   logic [W-1:0] mrel;
   int           held [W];

   always #5 clk = ~clk;

   system_btn_debounce #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .GAP_CYCLES      (G)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_n_in (btn_n_in),
      .btn_out  (btn_out),
      .press    (press),
      .released (released)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // The debounced level flips when the D samples seen through the two-flop
   // delay all disagree with it; repeat gaps follow from time held.
   always @(posedge clk or negedge reset_n) begin : model
      logic [W-1:0] ndb, np, nr, ng;
      int           nh [W];
      bit           stable;
      if (!reset_n) begin
         for (int k = 0; k <= D; k++) q[k] <= '1;
         mdb    <= '1;
         mgap   <= '0;
         mpress <= '0;
         mrel   <= '0;
         for (int c = 0; c < W; c++) held[c] <= 0;
      end else begin
         for (int c = 0; c < W; c++) begin
            stable = 1'b1;
            for (int k = 1; k <= D; k++)
               if (q[k][c] == mdb[c]) stable = 1'b0;
            ndb[c] = mdb[c];
            np[c]  = 1'b0;
            nr[c]  = 1'b0;
            ng[c]  = 1'b0;
            nh[c]  = held[c] + 1;
            if (stable) begin
               ndb[c] = ~mdb[c];
               if (!ndb[c]) begin
                  np[c] = 1'b1;
                  nh[c] = 0;
               end else begin
                  nr[c] = 1'b1;
               end
            end
            if (ndb[c]) nh[c] = 0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
            if (!ndb[c] && nh[c] >= RD) begin
               int t;
               t     = (nh[c] - RD) % (G + RP);
               ng[c] = (t < G);
               if (nh[c] >= RD + G && t == G) np[c] = 1'b1;
            end
`endif
         end
         mdb    <= ndb;
         mgap   <= ng;
         mpress <= np;
         mrel   <= nr;
         for (int c = 0; c < W; c++) held[c] <= nh[c];
         for (int k = 1; k <= D; k++) q[k] <= q[k-1];
         q[0] <= btn_n_in;
      end
   end

   always @(negedge clk) begin
      check("cyc_btn_out", btn_out, mdb | mgap);
      check("cyc_press", press, mpress);
      check("cyc_release", released, mrel);
      for (int c = 0; c < W; c++) begin
         press_seen[c] += int'(press[c]);
         rel_seen[c]   += int'(released[c]);
      end
   end

   initial begin
      int p0, r0, r2, r3;

      // Reset while all buttons are held down
      reset_n  = 1'b0;
      btn_n_in = '0;
      tick(3);
      check("t1_rst_out", btn_out, 4'hF);
      check("t1_rst_press", press, 4'h0);
      check("t1_rst_rel", released, 4'h0);
      reset_n = 1'b1;
      tick(1);
      check("t1_post_out", btn_out, 4'hF);
      check("t1_post_press", press, 4'h0);
      check("t1_post_rel", released, 4'h0);
      tick(20);
      btn_n_in = '1;
      tick(20);

      // Single press on channel 0: latency D+2 edges
      r0 = rel_seen[0];
      btn_n_in = 4'hE;
      tick(9);
      check("t2_edge9", btn_out[0], 1'b1);
      tick(1);
      check("t2_edge10", btn_out[0], 1'b0);
      check("t2_press", press, 4'h1);
      tick(1);
      check("t2_press_once", press, 4'h0);
      tick(20);
      check("t2_no_release", rel_seen[0] - r0, 0);
      btn_n_in = '1;
      tick(20);

      // Channel 1: D-1 low samples are rejected, D are accepted
      p0 = press_seen[1];
      btn_n_in[1] = 1'b0;
      tick(7);
      btn_n_in[1] = 1'b1;
      tick(20);
      check("t3_short_level", btn_out[1], 1'b1);
      check("t3_short_press", press_seen[1] - p0, 0);
      btn_n_in[1] = 1'b0;
      tick(8);
      btn_n_in[1] = 1'b1;
      tick(20);
      check("t3_full_press", press_seen[1] - p0, 1);
      check("t3_full_release", btn_out[1], 1'b1);

      // Channel 2: bounce every 3 cycles, then settle low
      p0 = press_seen[2];
      for (int i = 0; i < 20; i++) begin
         btn_n_in[2] = ~btn_n_in[2];
         tick(3);
      end
      check("t4_bounce_level", btn_out[2], 1'b1);
      btn_n_in[2] = 1'b0;
      tick(9);
      check("t4_settle9", btn_out[2], 1'b1);
      tick(1);
      check("t4_settle10", btn_out[2], 1'b0);
      tick(5);
      check("t4_single_press", press_seen[2] - p0, 1);
      btn_n_in[2] = 1'b1;
      tick(20);

      // Channels 2 and 3 together, then reset in the middle of a release count
      btn_n_in = 4'h3;
      tick(10);
      check("t5_coincide", press, 4'hC);
      tick(10);
      r2 = rel_seen[2];
      r3 = rel_seen[3];
      btn_n_in[2] = 1'b1;
      tick(15);
      check("t5_rel2", rel_seen[2] - r2, 1);
      check("t5_rel3_none", rel_seen[3] - r3, 0);
      check("t5_levels", btn_out, 4'h7);
      btn_n_in[3] = 1'b1;
      tick(5);
      reset_n = 1'b0;
      #1;
      check("t5_rst_out", btn_out, 4'hF);
      check("t5_rst_press", press, 4'h0);
      check("t5_rst_rel", released, 4'h0);
      tick(2);
      reset_n = 1'b1;
      tick(20);
      check("t5_no_rel3", rel_seen[3] - r3, 0);

      // Randomized hold lengths clustered around the debounce threshold
      for (int c = 0; c < W; c++) rem[c] = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         for (int c = 0; c < W; c++) begin
            if (rem[c] == 0) begin
               btn_n_in[c] = 1'($urandom_range(0, 1));
               rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 30))
                                                    : int'($urandom_range(1, 9));
            end
            rem[c]--;
         end
         tick(1);
      end
      btn_n_in = '1;
      tick(20);
      check("rnd_idle", btn_out, 4'hF);

`ifdef BTN_DEBOUNCE_REPEAT_EN
      // Auto-repeat on channel 0; release lands inside the fourth gap
      p0 = press_seen[0];
      r0 = rel_seen[0];
      btn_n_in[0] = 1'b0;
      tick(50);
      check("t6_gap1_start", btn_out[0], 1'b1);
      tick(3);
      check("t6_gap1_end", btn_out[0], 1'b1);
      tick(1);
      check("t6_rpt1_level", btn_out[0], 1'b0);
      check("t6_rpt1_press", press[0], 1'b1);
      tick(20);
      check("t6_gap2_start", btn_out[0], 1'b1);
      tick(39);
      btn_n_in[0] = 1'b1;
      tick(9);
      check("t6_gap4", btn_out[0], 1'b1);
      check("t6_gap4_press", press[0], 1'b0);
      tick(1);
      check("t6_release", released[0], 1'b1);
      tick(10);
      check("t6_press_total", press_seen[0] - p0, 4);
      check("t6_rel_total", rel_seen[0] - r0, 1);
      check("t6_idle", btn_out, 4'hF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
